// File: rtl/peripheral_noc_router_lookup_buffer_if.sv
// Handshake bundle between route lookup, the lookup buffer and the output switch.
// master = upstream/downstream environment side, slave = the buffer itself.
interface peripheral_noc_router_lookup_buffer_if #(
    parameter int FLIT_WIDTH = 32,
    parameter int OUTPUTS    = 7
);
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  in_last;
    logic [OUTPUTS-1:0]    in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] out_flit;
    logic                  out_last;
    logic [OUTPUTS-1:0]    out_valid;
    logic [OUTPUTS-1:0]    out_ready;

    modport master (
        output in_flit, in_last, in_valid, out_ready,
        input  in_ready, out_flit, out_last, out_valid
    );

    modport slave (
        input  in_flit, in_last, in_valid, out_ready,
        output in_ready, out_flit, out_last, out_valid
    );
endinterface

// File: rtl/peripheral_noc_router_lookup_buffer.sv
// DEPTH-entry elastic FIFO between route lookup and switch; in_ready comes only from registered occupancy.
// Optional statistics counters are enabled by PERIPHERAL_NOC_LOOKUP_BUFFER_STATS_EN.
module peripheral_noc_router_lookup_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int OUTPUTS    = 7,
    parameter int DEPTH      = 4,
    parameter int STAT_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    peripheral_noc_router_lookup_buffer_if.slave bus
`ifdef PERIPHERAL_NOC_LOOKUP_BUFFER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_stall,
    output logic [STAT_WIDTH-1:0] stat_flits
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FLIT_WIDTH-1:0] flit_mem_r [DEPTH];
    logic                  last_mem_r [DEPTH];
    logic [OUTPUTS-1:0]    sel_mem_r  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             in_ready_r;
    logic             head_valid_s;
    logic [OUTPUTS-1:0] out_valid_s;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
    endfunction

    // Head presentation and handshake decode
    always_comb begin
        head_valid_s = (count_r != {CNT_W{1'b0}});
        if (head_valid_s) begin
            out_valid_s = sel_mem_r[rd_ptr_r];
        end else begin
            out_valid_s = {OUTPUTS{1'b0}};
        end
        push_s = in_ready_r & (|bus.in_valid);
        pop_s  = |(out_valid_s & bus.out_ready);
    end

    // Next occupancy; in_ready is registered from this so out_ready never reaches in_ready combinationally
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy and backpressure state
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s != CNT_W'(DEPTH));
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
        end
    end

    // Entry storage; deliberately unreset, pointers alone define what is live
    always_ff @(posedge clk) begin
        if (push_s) begin
            flit_mem_r[wr_ptr_r] <= bus.in_flit;
            last_mem_r[wr_ptr_r] <= bus.in_last;
            sel_mem_r[wr_ptr_r]  <= bus.in_valid;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_flit  = flit_mem_r[rd_ptr_r];
    assign bus.out_last  = last_mem_r[rd_ptr_r];

`ifdef PERIPHERAL_NOC_LOOKUP_BUFFER_STATS_EN
    logic [STAT_WIDTH-1:0] stat_stall_r;
    logic [STAT_WIDTH-1:0] stat_flits_r;

    // Stall counter saturates, delivered-flit counter wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_r <= {STAT_WIDTH{1'b0}};
            stat_flits_r <= {STAT_WIDTH{1'b0}};
        end else begin
            if (head_valid_s && !pop_s && (stat_stall_r != {STAT_WIDTH{1'b1}})) begin
                stat_stall_r <= stat_stall_r + STAT_WIDTH'(1);
            end
            if (pop_s) begin
                stat_flits_r <= stat_flits_r + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_stall = stat_stall_r;
    assign stat_flits = stat_flits_r;
`endif

endmodule

// File: tb/tb_peripheral_noc_router_lookup_buffer.sv
// Directed bench for the lookup buffer: a DEPTH=4 and a DEPTH=3 instance share stimulus and are
// each checked every cycle against a queue model, plus hand-computed literal expectations.
module tb_peripheral_noc_router_lookup_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_flit = 32'h0;
    logic        in_last = 1'b0;
    logic [6:0]  in_valid = 7'h0;
    logic [6:0]  out_ready = 7'h0;

    always #5 clk = ~clk;

    peripheral_noc_router_lookup_buffer_if #(.FLIT_WIDTH(32), .OUTPUTS(7)) if4 ();
    peripheral_noc_router_lookup_buffer_if #(.FLIT_WIDTH(32), .OUTPUTS(7)) if3 ();

    assign if4.in_flit = in_flit;   assign if3.in_flit = in_flit;
    assign if4.in_last = in_last;   assign if3.in_last = in_last;
    assign if4.in_valid = in_valid; assign if3.in_valid = in_valid;
    assign if4.out_ready = out_ready; assign if3.out_ready = out_ready;

`ifdef PERIPHERAL_NOC_LOOKUP_BUFFER_STATS_EN
    logic [31:0] st_stall4, st_flits4, st_stall3, st_flits3;
`endif

    peripheral_noc_router_lookup_buffer #(.FLIT_WIDTH(32), .OUTPUTS(7), .DEPTH(4), .STAT_WIDTH(32)) dut4 (
        .clk(clk), .rst(rst), .bus(if4.slave)
`ifdef PERIPHERAL_NOC_LOOKUP_BUFFER_STATS_EN
        , .stat_stall(st_stall4), .stat_flits(st_flits4)
`endif
    );

    peripheral_noc_router_lookup_buffer #(.FLIT_WIDTH(32), .OUTPUTS(7), .DEPTH(3), .STAT_WIDTH(32)) dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave)
`ifdef PERIPHERAL_NOC_LOOKUP_BUFFER_STATS_EN
        , .stat_stall(st_stall3), .stat_flits(st_flits3)
`endif
    );

    typedef struct packed {
        logic [31:0] flit;
        logic        last;
        logic [6:0]  sel;
    } ent_t;

    ent_t        q4[$];
    ent_t        q3[$];
    logic [31:0] del3[$];
    logic [31:0] m_stall4 = 32'h0;
    logic [31:0] m_flits4 = 32'h0;
    bit          model_on = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: FIFO of accepted entries; a head pops when any of its selected outputs is ready
    always @(posedge clk) begin
        bit p4, h4, a4, p3, a3;
        if (rst) begin
            q4.delete(); q3.delete(); del3.delete();
            m_stall4 = 32'h0; m_flits4 = 32'h0;
            model_on = 1'b1;
        end else begin
            h4 = (q4.size() != 0);
            p4 = h4 && ((q4[0].sel & out_ready) != 7'h0);
            a4 = (q4.size() != 4) && (in_valid != 7'h0);
            if (h4 && !p4 && m_stall4 != 32'hFFFF_FFFF) m_stall4 = m_stall4 + 32'h1;
            if (p4) m_flits4 = m_flits4 + 32'h1;
            if (p4) void'(q4.pop_front());
            if (a4) q4.push_back({in_flit, in_last, in_valid});
            p3 = (q3.size() != 0) && ((q3[0].sel & out_ready) != 7'h0);
            a3 = (q3.size() != 3) && (in_valid != 7'h0);
            if (p3) begin
                del3.push_back(q3[0].flit);
                void'(q3.pop_front());
            end
            if (a3) q3.push_back({in_flit, in_last, in_valid});
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (model_on) begin
            chk("d4_out_valid", 64'(if4.out_valid), 64'((q4.size() != 0) ? q4[0].sel : 7'h0));
            chk("d4_in_ready", 64'(if4.in_ready), 64'(q4.size() != 4));
            if (q4.size() != 0) begin
                chk("d4_out_flit", 64'(if4.out_flit), 64'(q4[0].flit));
                chk("d4_out_last", 64'(if4.out_last), 64'(q4[0].last));
            end
            chk("d3_out_valid", 64'(if3.out_valid), 64'((q3.size() != 0) ? q3[0].sel : 7'h0));
            chk("d3_in_ready", 64'(if3.in_ready), 64'(q3.size() != 3));
            if (q3.size() != 0) begin
                chk("d3_out_flit", 64'(if3.out_flit), 64'(q3[0].flit));
                chk("d3_out_last", 64'(if3.out_last), 64'(q3[0].last));
            end
`ifdef PERIPHERAL_NOC_LOOKUP_BUFFER_STATS_EN
            chk("d4_stat_stall", 64'(st_stall4), 64'(m_stall4));
            chk("d4_stat_flits", 64'(st_flits4), 64'(m_flits4));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 7'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int sent;
        int cyc;
        bit acc;
        step();
        step();
        rst = 1'b0;
        chk("reset_out_valid", 64'(if4.out_valid), 64'h0);
        chk("reset_in_ready", 64'(if4.in_ready), 64'h1);

        // Streaming: one flit per cycle, one-cycle latency
        out_ready = 7'h7F;
        for (int i = 0; i < 8; i++) begin
            in_valid = 7'b0000100;
            in_flit  = 32'h10 + 32'(i);
            in_last  = (i == 7);
            step();
            chk("stream_valid", 64'(if4.out_valid), 64'h04);
            chk("stream_flit", 64'(if4.out_flit), 64'h10 + 64'(i));
            chk("stream_ready", 64'(if4.in_ready), 64'h1);
        end
        chk("stream_tail", 64'(if4.out_last), 64'h1);
        in_valid = 7'h0;
        in_last  = 1'b0;
        step();
        chk("stream_drained", 64'(if4.out_valid), 64'h0);

        // Fill with no acceptance, then a single pop
        out_ready = 7'h0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 7'b0000100;
            in_flit  = 32'hA0 + 32'(i);
            step();
            chk("fill_head", 64'(if4.out_flit), 64'hA0);
            chk("fill_ready", 64'(if4.in_ready), (i == 3) ? 64'h0 : 64'h1);
        end
        in_flit = 32'hA4;
        step();
        chk("full_ignored_head", 64'(if4.out_flit), 64'hA0);
        chk("full_ready", 64'(if4.in_ready), 64'h0);
        in_valid  = 7'h0;
        out_ready = 7'b0000100;
        step();
        chk("pop_next_head", 64'(if4.out_flit), 64'hA1);
        chk("pop_ready_back", 64'(if4.in_ready), 64'h1);
        out_ready = 7'h7F;
        step();
        chk("drain_a2", 64'(if4.out_flit), 64'hA2);
        step();
        chk("drain_a3", 64'(if4.out_flit), 64'hA3);
        step();
        chk("drain_no_a4", 64'(if4.out_valid), 64'h0);

        // Ready on a non-selected output never pops
        do_reset();
        out_ready = 7'b0000010;
        in_valid  = 7'b0000100;
        in_flit   = 32'hB0;
        step();
        in_valid = 7'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_head", 64'(if4.out_flit), 64'hB0);
            chk("stall_valid", 64'(if4.out_valid), 64'h04);
        end
`ifdef PERIPHERAL_NOC_LOOKUP_BUFFER_STATS_EN
        chk("stat_stall_10", 64'(st_stall4), 64'd10);
        chk("stat_flits_0", 64'(st_flits4), 64'd0);
`endif
        out_ready = 7'h7F;
        step();
        chk("stall_drained", 64'(if4.out_valid), 64'h0);

        // Multicast head pops when any selected output accepts
        out_ready = 7'h0;
        in_valid  = 7'b0011000;
        in_flit   = 32'hC0;
        step();
        in_valid  = 7'b0000001;
        in_flit   = 32'hC1;
        step();
        chk("mc_head_valid", 64'(if4.out_valid), 64'h18);
        chk("mc_head_flit", 64'(if4.out_flit), 64'hC0);
        in_valid  = 7'h0;
        out_ready = 7'b0001000;
        step();
        chk("mc_next_valid", 64'(if4.out_valid), 64'h01);
        chk("mc_next_flit", 64'(if4.out_flit), 64'hC1);
        out_ready = 7'h7F;
        step();

        // Pointer wrap on DEPTH=3 with random acceptance
        do_reset();
        sent = 0;
        cyc  = 0;
        while (del3.size() < 10 && cyc < 400) begin
            acc = 1'b0;
            if (sent < 10) begin
                in_valid = 7'b0000100;
                in_flit  = 32'hD0 + 32'(sent);
                acc      = (q3.size() != 3);
            end else begin
                in_valid = 7'h0;
            end
            out_ready = 7'($urandom_range(0, 127));
            step();
            if (acc) sent++;
            cyc++;
        end
        chk("wrap_delivered", 64'(del3.size()), 64'd10);
        for (int i = 0; i < del3.size(); i++) begin
            chk("wrap_order", 64'(del3[i]), 64'hD0 + 64'(i));
        end
        in_valid  = 7'h0;
        out_ready = 7'h7F;
        step();
        step();
        step();

        // Reset while full discards contents
        out_ready = 7'h0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 7'b0000100;
            in_flit  = 32'hE0 + 32'(i);
            step();
        end
        chk("pre_rst_full3", 64'(if3.in_ready), 64'h0);
        do_reset();
        chk("rst_out_valid3", 64'(if3.out_valid), 64'h0);
        chk("rst_in_ready3", 64'(if3.in_ready), 64'h1);
        chk("rst_out_valid4", 64'(if4.out_valid), 64'h0);
        in_valid = 7'b0000100;
        in_flit  = 32'h55;
        step();
        chk("post_rst_flit", 64'(if3.out_flit), 64'h55);
        chk("post_rst_valid", 64'(if3.out_valid), 64'h04);
        in_valid  = 7'h0;
        out_ready = 7'h7F;
        step();
        chk("post_rst_no_stale3", 64'(if3.out_valid), 64'h0);
        chk("post_rst_no_stale4", 64'(if4.out_valid), 64'h0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
